// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick link: word length, link FSM states and button bit map.
package joy_db15_pkg;

    localparam int unsigned JOY_NBITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } joy_state_e;

    localparam int unsigned BTN_R     = 0;
    localparam int unsigned BTN_L     = 1;
    localparam int unsigned BTN_D     = 2;
    localparam int unsigned BTN_U     = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_START = 7;

    // Line level is active low; P1 occupies the low byte so P1 R goes out first.
    function automatic logic [JOY_NBITS-1:0] joy_word(input logic [7:0] p1, input logic [7:0] p2);
        return ~{p2, p1};
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Single-bit button debouncer; only built when JOY_DB15_TX_DEBOUNCE_EN is defined.
`ifdef JOY_DB15_TX_DEBOUNCE_EN
module joy_debounce #(
    parameter int unsigned DEB_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Any sample agreeing with the current output restarts the stability count.
    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        if (sync_q[1] != dout_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                dout_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign dout = dout_q;

endmodule
`endif

// File: rtl/joy_db15_tx.sv
// DB15 joystick device-side responder: emulates the host-read '165 latch chain.
// Optional per-button debouncing is enabled with JOY_DB15_TX_DEBOUNCE_EN.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int unsigned NBITS       = JOY_NBITS,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       joy_load,
    input  logic       joy_clk,
    output logic       joy_data,
    input  logic [7:0] btn_p1,
    input  logic [7:0] btn_p2,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(NBITS + 1);

    if (SYNC_STAGES < 2 || NBITS != JOY_NBITS || DEB_CYCLES < 1) begin : g_param_check
        $error("joy_db15_tx: unsupported parameter set");
    end

    logic [SYNC_STAGES-1:0] load_sync_q, clk_sync_q;
    logic                   load_prev_q, clk_prev_q;
    logic                   load_s, clk_s;
    logic                   load_fall, load_rise, clk_rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_sync_q <= '1;
            clk_sync_q  <= '0;
            load_prev_q <= 1'b1;
            clk_prev_q  <= 1'b0;
        end else begin
            load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load};
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
            load_prev_q <= load_s;
            clk_prev_q  <= clk_s;
        end
    end

    assign load_s    = load_sync_q[SYNC_STAGES-1];
    assign clk_s     = clk_sync_q[SYNC_STAGES-1];
    assign load_fall = load_prev_q & ~load_s;
    assign load_rise = ~load_prev_q & load_s;
    assign clk_rise  = ~clk_prev_q & clk_s;

    logic [15:0]      btn_raw, btn_s;
    logic [NBITS-1:0] word;

    assign btn_raw = {btn_p2, btn_p1};

`ifdef JOY_DB15_TX_DEBOUNCE_EN
    for (genvar i = 0; i < 16; i++) begin : g_deb
        joy_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (btn_raw[i]),
            .dout   (btn_s[i])
        );
    end
`else
    logic [15:0] btn_meta_q, btn_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
        end
    end

    assign btn_s = btn_sync_q;
`endif

    assign word = joy_word(btn_s[7:0], btn_s[15:8]);

    joy_state_e       state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             frame_done_q, frame_done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '1;
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    // A load fall pre-empts everything, including a coincident clock rise.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        overrun_d    = overrun_q;
        frame_done_d = 1'b0;
        if (load_fall) begin
            state_d   = ST_LOAD;
            shreg_d   = word;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!load_s) begin
                        state_d   = ST_LOAD;
                        shreg_d   = word;
                        cnt_d     = '0;
                        overrun_d = 1'b0;
                    end
                end
                ST_LOAD: begin
                    shreg_d = word;
                    cnt_d   = '0;
                    if (load_rise) begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        shreg_d = {1'b1, shreg_q[NBITS-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CW'(NBITS - 1)) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (clk_rise) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // LOAD is transparent: the line follows the live word's first bit.
    always_comb begin
        joy_data = 1'b1;
        unique case (state_q)
            ST_LOAD:  joy_data = word[BTN_R];
            ST_SHIFT: joy_data = shreg_q[0];
            default:  joy_data = 1'b1;
        endcase
    end

    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
